// File: rtl/sign_extend_stream_if.sv
// Sample stream bundle for sign_extend_stream: upstream request side
// (valid/sample/width/mode), downstream response side (valid/result/err)
// and the ready signal that travels against each direction.
interface sign_extend_stream_if #(
    parameter int N = 12,
    parameter int M = 32
);
    localparam int WW = $clog2(N + 1);

    logic          i_valid;
    logic          o_ready;
    logic [N-1:0]  i_x;
    logic [WW-1:0] i_width;
    logic          i_mode;
    logic          o_valid;
    logic          i_ready;
    logic [M-1:0]  o_y;
    logic          o_err;

    // Block side: consumes samples and produces extended results.
    modport slave (
        input  i_valid, i_x, i_width, i_mode, i_ready,
        output o_ready, o_valid, o_y, o_err
    );

    // Environment side: offers samples and accepts results.
    modport master (
        output i_valid, i_x, i_width, i_mode, i_ready,
        input  o_ready, o_valid, o_y, o_err
    );
endinterface

// File: rtl/sign_extend_stream.sv
// Streaming sign/zero extender. Each accepted sample of W significant bits
// is widened to M bits and held in a two-entry (OUT + SKID) buffer so that
// o_ready is a pure register and never depends on i_ready in the same cycle.
module sign_extend_stream #(
    parameter int N = 12,
    parameter int M = 32
) (
    input logic                i_clk,
    input logic                i_rst_n,
    sign_extend_stream_if.slave bus
);
    localparam int WW = $clog2(N + 1);
    localparam logic [WW-1:0] N_W = WW'(N);

    typedef enum logic [1:0] {
        EMPTY,
        HALF,
        FULL
    } state_t;

    typedef struct packed {
        logic [M-1:0] y;
        logic         err;
    } sample_t;

    state_t  state_q, state_d;
    sample_t out_q,   out_d;
    sample_t skid_q,  skid_d;
    logic    ready_q, ready_d;
    sample_t new_s;
    logic [WW-1:0] eff_w;
    logic    sign_bit;
    logic    in_xfer;
    logic    out_xfer;

    assign in_xfer  = bus.i_valid && ready_q;
    assign out_xfer = (state_q != EMPTY) && bus.i_ready;

    // Extend the incoming sample; illegal widths fall back to the full N bits.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        new_s    = '0;
        eff_w    = bus.i_width;
        sign_bit = 1'b0;
        if (bus.i_width == '0 || bus.i_width > N_W) begin
            eff_w     = N_W;
            new_s.err = 1'b1;
        end
        for (int b = 0; b < N; b++) begin
            if (b == int'(eff_w) - 1) sign_bit = bus.i_x[b];
        end
        for (int j = 0; j < N; j++) begin
            if (j < int'(eff_w)) new_s.y[j] = bus.i_x[j];
            else                 new_s.y[j] = bus.i_mode & sign_bit;
        end
        for (int j = N; j < M; j++) begin
            new_s.y[j] = bus.i_mode & sign_bit;
        end
    end

    // Buffer state machine: decides where an accepted sample lands and what drains.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    out_d   = new_s;
                    state_d = HALF;
                end
            end
            HALF: begin
                if (in_xfer && out_xfer) begin
                    out_d = new_s;
                end else if (in_xfer) begin
                    skid_d  = new_s;
                    state_d = FULL;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    out_d   = skid_q;
                    state_d = HALF;
                end
            end
            default: state_d = EMPTY;
        endcase
        ready_d = (state_d != FULL);
    end

    // State, data and registered ready update; reset discards all held samples.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values, independent of statement order.
        if (!i_rst_n) begin
            state_q <= EMPTY;
            out_q   <= '0;
            // NOTE: the skid entry is reset too, so no stale payload can ever
            // be observed after a mid-operation reset.
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

    assign bus.o_ready = ready_q;
    assign bus.o_valid = (state_q != EMPTY);
    assign bus.o_y     = out_q.y;
    assign bus.o_err   = out_q.err;
endmodule

// File: tb/tb_sign_extend_stream.sv
// Directed bench for sign_extend_stream (N=12, M=32): table of extension
// vectors streamed back-to-back, then skid/backpressure and reset sequences.
module tb_sign_extend_stream;
    localparam int N  = 12;
    localparam int M  = 32;
    localparam int WW = $clog2(N + 1);

    logic i_clk;
    logic i_rst_n;
    int   total = 0;
    int   bad   = 0;

    sign_extend_stream_if #(.N(N), .M(M)) bus ();

    sign_extend_stream #(.N(N), .M(M)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    typedef struct {
        logic [N-1:0]  x;
        logic [WW-1:0] w;
        logic          mode;
        logic [M-1:0]  exp_y;
        logic          exp_err;
    } vec_t;

    vec_t vecs [12];

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [N-1:0] x, input logic [WW-1:0] w, input logic mode);
        bus.i_valid = v;
        bus.i_x     = x;
        bus.i_width = w;
        bus.i_mode  = mode;
    endtask

    task automatic check_out(input string name, input logic v, input logic [M-1:0] y, input logic e);
        check({name, ".valid"}, 64'(bus.o_valid), 64'(v));
        check({name, ".y"},     64'(bus.o_y),     64'(y));
        check({name, ".err"},   64'(bus.o_err),   64'(e));
    endtask

    initial begin
        vecs[0]  = '{12'h800, 4'd12, 1'b1, 32'hFFFF_F800, 1'b0};
        vecs[1]  = '{12'hABC, 4'd4,  1'b1, 32'hFFFF_FFFC, 1'b0};
        vecs[2]  = '{12'hABC, 4'd4,  1'b0, 32'h0000_000C, 1'b0};
        vecs[3]  = '{12'h7FF, 4'd0,  1'b1, 32'h0000_07FF, 1'b1};
        vecs[4]  = '{12'h7FF, 4'd13, 1'b1, 32'h0000_07FF, 1'b1};
        vecs[5]  = '{12'h800, 4'd12, 1'b0, 32'h0000_0800, 1'b0};
        vecs[6]  = '{12'h001, 4'd1,  1'b1, 32'hFFFF_FFFF, 1'b0};
        vecs[7]  = '{12'h002, 4'd1,  1'b1, 32'h0000_0000, 1'b0};
        vecs[8]  = '{12'hFFF, 4'd15, 1'b0, 32'h0000_0FFF, 1'b1};
        vecs[9]  = '{12'h5A5, 4'd8,  1'b1, 32'hFFFF_FFA5, 1'b0};
        vecs[10] = '{12'h5A5, 4'd7,  1'b1, 32'h0000_0025, 1'b0};
        vecs[11] = '{12'h6B3, 4'd11, 1'b1, 32'hFFFF_FEB3, 1'b0};

        // Reset state, held across a clock edge with a sample offered.
        i_rst_n     = 1'b0;
        bus.i_ready = 1'b1;
        drive(1'b1, 12'h123, 4'd12, 1'b1);
        repeat (2) @(negedge i_clk);
        check_out("reset", 1'b0, '0, 1'b0);
        check("reset.ready", 64'(bus.o_ready), 64'd1);
        drive(1'b0, '0, '0, 1'b0);
        i_rst_n = 1'b1;

        // Back-to-back stream with i_ready=1: one result per cycle, ready stays 1.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].x, vecs[i].w, vecs[i].mode);
            @(negedge i_clk);
            check_out($sformatf("vec%0d", i), 1'b1, vecs[i].exp_y, vecs[i].exp_err);
            check($sformatf("vec%0d.ready", i), 64'(bus.o_ready), 64'd1);
        end
        drive(1'b0, '0, '0, 1'b0);
        @(negedge i_clk);
        check("drain.valid", 64'(bus.o_valid), 64'd0);

        // Backpressure: A and B accepted, C stalled, then drained in order.
        bus.i_ready = 1'b0;
        drive(1'b1, vecs[0].x, vecs[0].w, vecs[0].mode);
        @(negedge i_clk);
        check_out("skidA", 1'b1, vecs[0].exp_y, vecs[0].exp_err);
        check("skidA.ready", 64'(bus.o_ready), 64'd1);
        drive(1'b1, vecs[1].x, vecs[1].w, vecs[1].mode);
        @(negedge i_clk);
        check_out("skidB", 1'b1, vecs[0].exp_y, vecs[0].exp_err);
        check("skidB.ready", 64'(bus.o_ready), 64'd0);
        drive(1'b1, vecs[3].x, vecs[3].w, vecs[3].mode);
        @(negedge i_clk);
        check_out("skidC.hold", 1'b1, vecs[0].exp_y, vecs[0].exp_err);
        check("skidC.ready", 64'(bus.o_ready), 64'd0);
        bus.i_ready = 1'b1;
        @(negedge i_clk);
        check_out("drainB", 1'b1, vecs[1].exp_y, vecs[1].exp_err);
        check("drainB.ready", 64'(bus.o_ready), 64'd1);
        @(negedge i_clk);
        check_out("drainC", 1'b1, vecs[3].exp_y, vecs[3].exp_err);
        drive(1'b0, '0, '0, 1'b0);
        @(negedge i_clk);
        check("drainC.empty", 64'(bus.o_valid), 64'd0);

        // Fill to FULL, then async reset between edges.
        bus.i_ready = 1'b0;
        drive(1'b1, vecs[9].x, vecs[9].w, vecs[9].mode);
        @(negedge i_clk);
        drive(1'b1, vecs[3].x, vecs[3].w, vecs[3].mode);
        @(negedge i_clk);
        check("full.ready", 64'(bus.o_ready), 64'd0);
        #2 i_rst_n = 1'b0;
        #1;
        check_out("midrst", 1'b0, '0, 1'b0);
        check("midrst.ready", 64'(bus.o_ready), 64'd1);
        @(negedge i_clk);
        check_out("midrst.held", 1'b0, '0, 1'b0);
        i_rst_n     = 1'b1;
        bus.i_ready = 1'b1;
        drive(1'b1, vecs[2].x, vecs[2].w, vecs[2].mode);
        @(negedge i_clk);
        check_out("postrst", 1'b1, vecs[2].exp_y, vecs[2].exp_err);
        drive(1'b0, '0, '0, 1'b0);
        @(negedge i_clk);
        check("postrst.empty", 64'(bus.o_valid), 64'd0);
        check("postrst.ready", 64'(bus.o_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sign_extend_stream.md
SIGN_EXTEND_STREAM -- requirements
Module: sign_extend_stream

Interface
REQ-001 SHALL have parameter N, default 12: maximum source sample width in bits; legal range N >= 2.
REQ-002 SHALL have parameter M, default 32: output width in bits; legal range M >= N.
REQ-003 SHALL have derived parameter WW = $clog2(N+1): width of the per-sample width field.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports named i_clk and i_rst_n.
REQ-005 i_clk  input  1  clock; all state updates on the rising edge.
REQ-006 i_rst_n  input  1  asynchronous active-low reset.
REQ-007 i_valid  input  1  upstream sample valid.
REQ-008 o_ready  output  1  block can accept a sample this cycle.
REQ-009 i_x  input  N  source sample; only bits [W-1:0] are significant.
REQ-010 i_width  input  WW  effective source width W for this sample.
REQ-011 i_mode  input  1  extension mode: 1 = sign-extend, 0 = zero-extend.
REQ-012 o_valid  output  1  output sample valid.
REQ-013 i_ready  input  1  downstream accepts the output sample.
REQ-014 o_y  output  M  extended sample.
REQ-015 o_err  output  1  set when the sample in o_y had an illegal width field.

Function
REQ-016 Input transfer SHALL occur when i_valid && o_ready on a rising clock edge.
REQ-017 Output transfer SHALL occur when o_valid && i_ready on a rising clock edge.
REQ-018 Legal width: 1 <= i_width <= N, and W = i_width.
REQ-019 Illegal width: i_width == 0 or i_width > N SHALL be treated as W = N, and that sample's o_err SHALL be 1.
REQ-020 o_y bits [W-1:0] SHALL equal i_x[W-1:0].
REQ-021 o_y bits [M-1:W] SHALL equal i_x[W-1] when i_mode = 1, and SHALL be 0 when i_mode = 0.
REQ-022 i_x bits [N-1:W] SHALL be ignored.
REQ-023 Extension SHALL be computed combinationally from the input and captured in registers; width, mode and error are evaluated per sample at acceptance time.
REQ-024 Latency SHALL be 1 cycle: a sample accepted at edge k appears on o_y/o_err with o_valid = 1 after edge k.
REQ-025 The block SHALL contain an output register (OUT) and one skid register (SKID); the state machine states are EMPTY (neither holds data), HALF (OUT holds data) and FULL (OUT and SKID hold data).
REQ-026 EMPTY: on an input transfer, the sample goes to OUT and the state becomes HALF.
REQ-027 HALF, input transfer and output transfer together: the new sample replaces OUT and the state stays HALF.
REQ-028 HALF, input transfer only: the new sample goes to SKID and the state becomes FULL.
REQ-029 HALF, output transfer only: the state becomes EMPTY.
REQ-030 FULL, output transfer: SKID moves to OUT and the state becomes HALF; no input transfer is possible in FULL.
REQ-031 o_ready SHALL be a registered signal equal to (state != FULL); it SHALL not depend combinationally on i_ready.
REQ-032 o_valid SHALL equal (state != EMPTY).
REQ-033 Samples SHALL leave in acceptance order, with no loss or duplication.
REQ-034 With i_ready held at 1, the block SHALL sustain one sample per cycle.
REQ-035 While o_valid = 1 && i_ready = 0, o_y and o_err SHALL hold stable.
REQ-036 i_valid asserted while o_ready = 0 SHALL have no effect; the upstream holds the sample.

Reset
REQ-037 While i_rst_n = 0, state SHALL be EMPTY, o_valid = 0, o_ready = 1, o_y = 0 and o_err = 0, regardless of the clock.
REQ-038 Assertion of reset mid-operation (HALF or FULL) SHALL discard all held samples immediately.
REQ-039 No transfer SHALL occur on any edge while i_rst_n = 0.
REQ-040 After reset release, the first input transfer SHALL be possible on the first rising edge.

Verification
REQ-041 N=12, M=32: i_x=12'h800, i_width=12, i_mode=1 -> next cycle o_valid=1, o_y=32'hFFFF_F800, o_err=0.
REQ-042 i_x=12'hABC, i_width=4: with i_mode=1 -> o_y=32'hFFFF_FFFC; with i_mode=0 -> o_y=32'h0000_000C; both with o_err=0.
REQ-043 i_x=12'h7FF, i_mode=1: with i_width=0 and with i_width=13 -> o_y=32'h0000_07FF and o_err=1 in both cases.
REQ-044 i_ready=0, three back-to-back samples A, B, C offered -> A and B accepted, o_ready=0 after B, C stalled; then raise i_ready -> A, B, C emitted in order on consecutive cycles.
REQ-045 i_ready=1, eight consecutive valid samples -> eight outputs on eight consecutive cycles, o_ready constant 1.
REQ-046 Fill to FULL, then pulse i_rst_n low between clock edges -> o_valid=0, o_ready=1, o_y=0 immediately; after release, a new sample is output correctly with no stale data.
